// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the RV32E pipeline.
// Owns the PC and keeps at most one word read outstanding to instruction memory. Each
// response becomes a {pc, instr, fault} entry on a ready/valid output port. A one-entry hold
// register catches a response that arrives while the output register is still occupied, so
// backpressure never drops an instruction. Redirects from execute flush the output, the hold
// entry and any in-flight response.
//
// Ports:
//   clock, nreset                   rising-edge clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     PC change request from execute (pc bits [1:0] ignored)
//   mem_req_valid/ready/addr        word read request to instruction memory
//   mem_rsp_valid/data/error        read response (never stalled), error marks an access fault
//   down_valid/ready                output handshake towards decode
//   down_pc, down_instr, down_fault output entry (instr forced to 0 on a fault)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_error,
  output logic        down_valid,
  input  logic        down_ready,
  output logic [31:0] down_pc,
  output logic [31:0] down_instr,
  output logic        down_fault
);

  localparam logic [2:0] StRequest = 3'd0;
  localparam logic [2:0] StWait    = 3'd1;
  localparam logic [2:0] StHold    = 3'd2;
  localparam logic [2:0] StDrain   = 3'd3;
  localparam logic [2:0] StHalt    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_fault_q, out_fault_d;

  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_fault_q, hold_fault_d;

  logic        slot_free;
  logic [31:0] rsp_instr;

  assign slot_free = !out_valid_q || down_ready;
  assign rsp_instr = mem_rsp_error ? 32'h0 : mem_rsp_data;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_fault_d  = out_fault_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    hold_fault_d = hold_fault_q;

    if (out_valid_q && down_ready) begin
      out_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      pc_d         = redirect_pc & ~32'h3;
      out_valid_d  = 1'b0;
      hold_valid_d = 1'b0;
      // A request accepted or still in flight must have its response swallowed in StDrain.
      case (state_q)
        StRequest: state_d = mem_req_ready ? StDrain : StRequest;
        StWait:    state_d = mem_rsp_valid ? StRequest : StDrain;
        StDrain:   state_d = mem_rsp_valid ? StRequest : StDrain;
        default:   state_d = StRequest;
      endcase
    end else begin
      case (state_q)
        StRequest: begin
          if (mem_req_ready) begin
            req_pc_d = pc_q;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (mem_rsp_valid) begin
            pc_d = req_pc_q + 32'd4;
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_pc_d    = req_pc_q;
              out_instr_d = rsp_instr;
              out_fault_d = mem_rsp_error;
              state_d     = mem_rsp_error ? StHalt : StRequest;
            end else begin
              // A held fault still halts, once it has moved to the output in StHold.
              hold_valid_d = 1'b1;
              hold_pc_d    = req_pc_q;
              hold_instr_d = rsp_instr;
              hold_fault_d = mem_rsp_error;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (down_ready && hold_valid_q) begin
            out_valid_d  = 1'b1;
            out_pc_d     = hold_pc_q;
            out_instr_d  = hold_instr_q;
            out_fault_d  = hold_fault_q;
            hold_valid_d = 1'b0;
            state_d      = hold_fault_q ? StHalt : StRequest;
          end
        end
        StDrain: begin
          if (mem_rsp_valid) begin
            state_d = StRequest;
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: state_d = StRequest;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= StRequest;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'h0;
      out_instr_q  <= 32'h0;
      out_fault_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_fault_q  <= out_fault_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_fault_q <= hold_fault_d;
    end
  end

  // State resets to StRequest, so the request is gated while reset is held.
  assign mem_req_valid = nreset && (state_q == StRequest);
  assign mem_req_addr  = pc_q;

  assign down_valid = out_valid_q;
  assign down_pc    = out_pc_q;
  assign down_instr = out_instr_q;
  assign down_fault = out_fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        nreset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_error;
  logic        down_valid;
  logic        down_ready;
  logic [31:0] down_pc;
  logic [31:0] down_instr;
  logic        down_fault;

  always #5 clock = ~clock;

  fetch_stage #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_error (mem_rsp_error),
    .down_valid    (down_valid),
    .down_ready    (down_ready),
    .down_pc       (down_pc),
    .down_instr    (down_instr),
    .down_fault    (down_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  entry_t      exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic        err_en;
  logic [31:0] err_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h00A0_0093;
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after each rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_pops(input int target);
    for (int i = 0; i < 30 && pops < target; i++) step();
    check32("delivery_count", pops, target);
  endtask

  // Memory: a request accepted on an edge is answered throughout the following cycle.
  initial begin : memory
    logic        fire;
    logic [31:0] a;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_rsp_error = 1'b0;
    forever begin
      @(negedge clock);
      fire = nreset && mem_req_valid && mem_req_ready;
      a    = mem_req_addr;
      @(posedge clock);
      #1;
      mem_rsp_valid = fire;
      mem_rsp_data  = fire ? mem_word(a) : 32'h0;
      mem_rsp_error = fire && err_en && (a == err_addr);
    end
  end

  // Monitor: every transfer on the output port is popped against the scoreboard.
  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clock);
      if (nreset && down_valid && down_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry: got pc=%h instr=%h fault=%b expected none",
                   down_pc, down_instr, down_fault);
        end else begin
          e = exp_q.pop_front();
          if (down_pc !== e.pc || down_instr !== e.instr || down_fault !== e.fault) begin
            errors++;
            $display("FAIL entry: got pc=%h instr=%h fault=%b expected pc=%h instr=%h fault=%b",
                     down_pc, down_instr, down_fault, e.pc, e.instr, e.fault);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int req_cycles;
    nreset         = 1'b0;
    down_ready     = 1'b1;
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    err_en         = 1'b0;
    err_addr       = 32'h0;

    #2;
    check32("rst_down_valid", {31'h0, down_valid}, 32'h0);
    check32("rst_down_pc", down_pc, 32'h0);
    check32("rst_down_instr", down_instr, 32'h0);
    check32("rst_down_fault", {31'h0, down_fault}, 32'h0);
    check32("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);

    // First fetch after reset.
    step();
    step();
    nreset = 1'b1;
    push(32'h0000_0100, 32'h00A0_0093, 1'b0);
    step();
    mem_req_ready = 1'b0;
    step();
    check32("first_down_valid", {31'h0, down_valid}, 32'h1);
    check32("first_down_pc", down_pc, 32'h0000_0100);
    check32("next_req_valid", {31'h0, mem_req_valid}, 32'h1);
    check32("next_req_addr", mem_req_addr, 32'h0000_0104);
    wait_pops(1);

    // Backpressure: 0x100 sits in the output, 0x104 in hold, no requests.
    down_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    push(32'h0000_0100, 32'h00A0_0093, 1'b0);
    push(32'h0000_0104, 32'h5A5A_0117, 1'b0);
    step();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    check32("restart_addr", mem_req_addr, 32'h0000_0100);
    repeat (6) step();
    check32("bp_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check32("bp_down_valid", {31'h0, down_valid}, 32'h1);
    check32("bp_down_pc", down_pc, 32'h0000_0100);
    check32("bp_pops", pops, 1);
    down_ready = 1'b1;
    step();
    check32("unhold_down_pc", down_pc, 32'h0000_0104);
    check32("unhold_req_addr", mem_req_addr, 32'h0000_0108);
    check32("unhold_req_valid", {31'h0, mem_req_valid}, 32'h1);

    // Redirect on the edge that accepts 0x108: stale response must be drained.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    push(32'h0000_0200, 32'h5A5A_0213, 1'b0);
    step();
    redirect_valid = 1'b0;
    check32("drain_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check32("drain_req_addr", mem_req_addr, 32'h0000_0200);
    check32("drain_down_valid", {31'h0, down_valid}, 32'h0);
    check32("drain_pops", pops, 3);
    step();
    check32("post_drain_req_valid", {31'h0, mem_req_valid}, 32'h1);
    step();
    mem_req_ready = 1'b0;
    wait_pops(4);

    // Redirect coincident with the response in WAIT: response discarded.
    mem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    mem_req_ready  = 1'b0;
    step();
    redirect_valid = 1'b0;
    check32("wait_redir_down_valid", {31'h0, down_valid}, 32'h0);
    check32("wait_redir_req_valid", {31'h0, mem_req_valid}, 32'h1);
    check32("wait_redir_req_addr", mem_req_addr, 32'h0000_0300);
    step();
    check32("wait_redir_pops", pops, 4);

    // Access fault halts fetching until a redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    err_en         = 1'b1;
    err_addr       = 32'h0000_0040;
    push(32'h0000_0040, 32'h0000_0000, 1'b1);
    step();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    check32("fault_req_addr", mem_req_addr, 32'h0000_0040);
    step();
    step();
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) req_cycles++;
      step();
    end
    check32("halt_req_cycles", req_cycles, 0);
    wait_pops(5);
    err_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    push(32'h0000_0080, 32'h5A5A_0093, 1'b0);
    step();
    redirect_valid = 1'b0;
    check32("resume_req_valid", {31'h0, mem_req_valid}, 32'h1);
    check32("resume_req_addr", mem_req_addr, 32'h0000_0080);
    step();
    mem_req_ready = 1'b0;
    wait_pops(6);

    // PC wraps from the top word to zero.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC, 32'hA5A5_FFEF, 1'b0);
    step();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    step();
    mem_req_ready = 1'b0;
    wait_pops(7);
    check32("wrap_req_addr", mem_req_addr, 32'h0000_0000);
    check32("wrap_req_valid", {31'h0, mem_req_valid}, 32'h1);
    check32("wrap_fault", {31'h0, down_fault}, 32'h0);

    // Asynchronous reset in the middle of WAIT.
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    nreset = 1'b0;
    #1;
    check32("arst_down_valid", {31'h0, down_valid}, 32'h0);
    check32("arst_down_pc", down_pc, 32'h0);
    check32("arst_down_instr", down_instr, 32'h0);
    check32("arst_down_fault", {31'h0, down_fault}, 32'h0);
    check32("arst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check32("arst_req_addr", mem_req_addr, 32'h0000_0100);
    step();
    check32("leftover_expected", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
